lane_scanner: RTL and testbench

//  Reader side of the 1-bit register bank that holds per-lane game flags (enemy/wave occupancy).
//  On start, snapshots the WIDTH flag bits and walks them LSB->MSB.

---
 rtl/lane_scanner.sv | 126 ++++++++++++
 tb/tb_lane_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_scanner.sv
// Snapshots WIDTH flag bits on start and presents each set-bit index LSB->MSB over valid/ready,
// then pulses a one-hot clear; first index valid k+2 edges after start, held until out_ready.
module lane_scanner #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lanes,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] clr_mask,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_snap;
    logic [IDX_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_clr_mask;

    logic w_hs;
    logic w_bit;
    logic w_last;

    assign w_hs   = (r_state == S_PRESENT) && r_out_valid && out_ready && !abort;
    assign w_bit  = r_snap[r_ptr];
    assign w_last = (r_ptr == LAST_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next = (|lanes) ? S_SCAN : S_DONE;
                    end
                end
                S_SCAN: begin
                    if (w_bit) begin
                        w_next = S_PRESENT;
                    end else if (w_last) begin
                        w_next = S_DONE;
                    end
                end
                S_PRESENT: begin
                    if (w_hs) begin
                        w_next = w_last ? S_DONE : S_SCAN;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // out_valid is registered off the state, so it rises one edge after PRESENT is entered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_snap      <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_clr_mask  <= '0;
        end else begin
            r_clr_mask  <= '0;
            r_out_valid <= (r_state == S_PRESENT) && !w_hs && !abort;
            if (!abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (start && (|lanes)) begin
                            r_snap <= lanes;
                            r_ptr  <= '0;
                        end
                    end
                    S_SCAN: begin
                        if (!w_bit && !w_last) begin
                            r_ptr <= r_ptr + IDX_W'(1);
                        end
                    end
                    S_PRESENT: begin
                        if (w_hs) begin
                            r_snap[r_ptr] <= 1'b0;
                            r_clr_mask    <= WIDTH'(1) << r_ptr;
                            if (!w_last) begin
                                r_ptr <= r_ptr + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_index = r_ptr;
    assign clr_mask  = r_clr_mask;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_lane_scanner.sv
// Randomized scoreboard bench for lane_scanner: stimulus queues expected indices, a negedge monitor checks them.
module tb_lane_scanner;
    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             start     = 1'b0;
    logic             abort     = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] lanes     = '0;
    logic             out_valid;
    logic [IDX_W-1:0] out_index;
    logic [WIDTH-1:0] clr_mask;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected index sequence, pending done pulses, timing anchor.
    int exp_idx_q[$];
    int exp_done = 0;
    int ref_edge = 0;
    int ref_pos  = -1;
    int edge_cnt = 0;
    bit rdy_rand  = 1'b0;
    bit rdy_fixed = 1'b0;

    lane_scanner #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .lanes     (lanes),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_index (out_index),
        .clr_mask  (clr_mask),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt++;

    always @(posedge clock) begin
        #2;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks timing against the model.
    logic [WIDTH-1:0] exp_clr    = '0;
    bit               prev_valid = 1'b0;
    bit               prev_hs    = 1'b0;
    bit               prev_abort = 1'b0;
    logic [IDX_W-1:0] prev_idx   = '0;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            prev_abort = 1'b0;
            exp_clr    = '0;
        end else begin
            bit hs;
            chk("clr_mask", clr_mask, exp_clr);
            exp_clr = '0;
            if (done) begin
                if (exp_done == 0) chk("unexpected_done", done, 0);
                else begin
                    chk("done_edge", edge_cnt, ref_edge + (WIDTH - 1 - ref_pos));
                    exp_done--;
                end
            end
            if (out_valid && !prev_valid) begin
                if (exp_idx_q.size() == 0) chk("unexpected_valid", out_valid, 0);
                else chk("present_latency", edge_cnt, ref_edge + exp_idx_q[0] - ref_pos + 1);
            end
            if (prev_valid && out_valid && !prev_hs) chk("index_held", out_index, prev_idx);
            if (prev_valid && !out_valid && !prev_hs && !prev_abort) chk("valid_dropped", out_valid, 1);
            hs = out_valid && out_ready && !abort;
            if (hs && exp_idx_q.size() != 0) begin
                int j;
                j = exp_idx_q.pop_front();
                chk("out_index", out_index, j);
                exp_clr  = WIDTH'(1) << j;
                ref_edge = edge_cnt + 1;
                ref_pos  = j;
            end
            if (abort) begin
                exp_idx_q.delete();
                exp_done = 0;
            end
            prev_valid = out_valid;
            prev_hs    = hs;
            prev_abort = abort;
            prev_idx   = out_index;
        end
    end

    task automatic start_scan(input logic [WIDTH-1:0] v);
        @(posedge clock); #1;
        lanes    = v;
        start    = 1'b1;
        ref_edge = edge_cnt + 1;
        ref_pos  = (v == '0) ? WIDTH - 1 : -1;
        for (int i = 0; i < WIDTH; i++) if (v[i]) exp_idx_q.push_back(i);
        exp_done++;
        @(posedge clock); #1;
        start = 1'b0;
        lanes = WIDTH'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((exp_done != 0 || exp_idx_q.size() != 0) && c < 500) begin
            @(posedge clock);
            c++;
        end
        if (exp_done != 0 || exp_idx_q.size() != 0) begin
            chk("scan_completion_timeout", exp_done + exp_idx_q.size(), 0);
            exp_done = 0;
            exp_idx_q.delete();
        end
        @(posedge clock); #1;
        chk("idle_after_done", busy, 0);
    endtask

    task automatic run_scan(input logic [WIDTH-1:0] v);
        start_scan(v);
        wait_idle();
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!out_valid && c < 40) begin
            @(posedge clock); #1;
            c++;
        end
        chk("valid_seen", out_valid, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_index"}, out_index, 0);
        chk({tag, "_clr_mask"}, clr_mask, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        #3;
        chk_all_zero("reset");
        #10 reset_n = 1'b1;

        // Empty lanes: done on the start edge, nothing presented.
        rdy_fixed = 1'b1;
        run_scan('0);

        // Both ends of the bank with an always-ready consumer.
        run_scan(16'h8001);

        // Backpressure hold with lanes changing after the snapshot.
        rdy_fixed = 1'b0;
        start_scan(16'h0010);
        lanes = 16'hFFFF;
        wait_valid();
        repeat (5) @(posedge clock);
        #1;
        chk("hold_out_index", out_index, 4);
        chk("hold_out_valid", out_valid, 1);
        rdy_fixed = 1'b1;
        wait_idle();

        // Abort while presenting index 1, with a handshake offered in the same cycle.
        rdy_fixed = 1'b0;
        start_scan(16'h0006);
        wait_valid();
        chk("abort_index", out_index, 1);
        abort     = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clock); #1;
        abort     = 1'b0;
        rdy_fixed = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_clr_mask", clr_mask, 0);
        repeat (20) @(posedge clock);

        // Asynchronous reset mid-scan.
        rdy_rand = 1'b1;
        start_scan(16'h8000);
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_idx_q.delete();
        exp_done = 0;
        @(posedge clock); #3;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);

        // Start while busy is ignored.
        start_scan(16'h0003);
        @(posedge clock); #1;
        start = 1'b1;
        lanes = 16'hF0F0;
        @(posedge clock); #1;
        start = 1'b0;
        wait_idle();

        // Randomized scans with a random-ready consumer.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) v = '0;
            else if ($urandom_range(0, 1) == 1) v = WIDTH'($urandom);
            else v = WIDTH'($urandom & $urandom & $urandom);
            run_scan(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
